// File: rtl/slot_display_driver_pkg.sv
// Shared types and constants for the slot machine 7-segment display driver:
// FSM states, segment glyphs ({g,f,e,d,c,b,a}, active-high) and field layout.
package slot_disp_pkg;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_F, S_SHIFT_F, S_LOAD_B, S_SHIFT_B, S_COMMIT
   } state_e;

   localparam int BCD_DIG = 10;

   localparam logic [6:0] GLYPH_0    = 7'h3F;
   localparam logic [6:0] GLYPH_1    = 7'h06;
   localparam logic [6:0] GLYPH_2    = 7'h5B;
   localparam logic [6:0] GLYPH_3    = 7'h4F;
   localparam logic [6:0] GLYPH_4    = 7'h66;
   localparam logic [6:0] GLYPH_5    = 7'h6D;
   localparam logic [6:0] GLYPH_6    = 7'h7D;
   localparam logic [6:0] GLYPH_7    = 7'h07;
   localparam logic [6:0] GLYPH_8    = 7'h7F;
   localparam logic [6:0] GLYPH_9    = 7'h6F;
   localparam logic [6:0] GLYPH_DASH = 7'h40;

   // Fixed single-digit fields, offset from the end of the bet field
   localparam int OFS_WHEEL0 = 0;
   localparam int OFS_WHEEL1 = 1;
   localparam int OFS_WHEEL2 = 2;
   localparam int OFS_DICE   = 3;
   localparam int NFIXED     = 4;

   function automatic int ndig(int fd, int bd);
      return fd + bd + NFIXED;
   endfunction

   function automatic logic [6:0] seg7(logic [3:0] d);
      case (d)
         4'd0:    return GLYPH_0;
         4'd1:    return GLYPH_1;
         4'd2:    return GLYPH_2;
         4'd3:    return GLYPH_3;
         4'd4:    return GLYPH_4;
         4'd5:    return GLYPH_5;
         4'd6:    return GLYPH_6;
         4'd7:    return GLYPH_7;
         4'd8:    return GLYPH_8;
         4'd9:    return GLYPH_9;
         default: return 7'h00;
      endcase
   endfunction

endpackage

// File: rtl/slot_display_driver_if.sv
// Game-core to display-driver bundle: display values in, segment/anode pins out.
interface slot_display_driver_if #(parameter int NDIG = 11);
   logic [31:0]     displayfunds;
   logic [31:0]     displaybet;
   logic [2:0]      displaywheel0;
   logic [2:0]      displaywheel1;
   logic [2:0]      displaywheel2;
   logic [2:0]      displaydice;
   logic [6:0]      seg;
   logic [NDIG-1:0] an;
   logic            ovf;

   modport master (output displayfunds, displaybet, displaywheel0, displaywheel1,
                   displaywheel2, displaydice, input seg, an, ovf);
   modport slave  (input displayfunds, displaybet, displaywheel0, displaywheel1,
                   displaywheel2, displaydice, output seg, an, ovf);
endinterface

// File: rtl/slot_display_driver_bin2bcd_seq.sv
// Sequential 32-bit binary to 10-digit BCD converter (shift-add-3), one bit per cycle.
// start_i loads the operand; busy_o covers the 32 shift cycles; done_o marks the final one.
module bin2bcd_seq
   import slot_disp_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_i,
   input  logic [31:0]            bin_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [4*BCD_DIG-1:0]   bcd_o
);
   logic [31:0]          bin_q;
   logic [4*BCD_DIG-1:0] bcd_q, adj_d;
   logic [4:0]           cnt_q;
   logic                 busy_q;

   always_comb begin
      adj_d = bcd_q;
      for (int n = 0; n < BCD_DIG; n++)
         if (bcd_q[4*n +: 4] >= 4'd5) adj_d[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (start_i) begin
         bin_q  <= bin_i;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b1;
      end else if (busy_q) begin
         {bcd_q, bin_q} <= {adj_d, bin_q} << 1;
         cnt_q <= cnt_q + 5'd1;
         if (cnt_q == 5'd31) busy_q <= 1'b0;
      end
   end

   assign busy_o = busy_q;
   assign done_o = busy_q && (cnt_q == 5'd31);
   assign bcd_o  = bcd_q;
endmodule

// File: rtl/slot_display_driver.sv
// Snapshots game display values, converts funds/bet to saturated BCD once per 68-cycle
// frame and scans all fields onto a multiplexed 7-segment bank. LEADING_ZERO_BLANK_EN blanks leading zeros.
module slot_display_driver
   import slot_disp_pkg::*;
#(
   parameter int SCAN_DIV  = 50000,
   parameter int FUNDS_DIG = 4,
   parameter int BET_DIG   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   slot_display_driver_if.slave  disp
);
   localparam int NDIG = ndig(FUNDS_DIG, BET_DIG);
   localparam int DW   = $clog2(NDIG);
   localparam int CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BASE = FUNDS_DIG + BET_DIG;
   localparam int FW   = 4 * FUNDS_DIG;
   localparam int BW   = 4 * BET_DIG;

   state_e                     state_q;
   logic [31:0]                bet_sh_q;
   logic [2:0]                 w0_sh_q, w1_sh_q, w2_sh_q, dice_sh_q;
   logic [4*BCD_DIG-1:0]       fbcd_q;
   logic [FUNDS_DIG-1:0][3:0]  funds_q;
   logic [BET_DIG-1:0][3:0]    bet_q;
   logic [2:0]                 w0_q, w1_q, w2_q, dice_q;
   logic                       ovf_q;
   logic [CW-1:0]              cnt_q;
   logic [DW-1:0]              dig_q;
   logic [6:0]                 seg_q, seg_d;
   logic [NDIG-1:0]            an_q;

   logic                       cv_start, cv_busy, cv_done;
   logic [31:0]                cv_bin;
   logic [4*BCD_DIG-1:0]       cv_bcd;
   logic                       f_sat, b_sat;
   logic [3:0]                 val [NDIG];
   logic [NDIG-1:0]            blank;

   // One converter serves both fields: funds first, bet from its shadow copy
   assign cv_start = (state_q == S_LOAD_F || state_q == S_LOAD_B) && !cv_busy;
   assign cv_bin   = (state_q == S_LOAD_F) ? disp.displayfunds : bet_sh_q;
   assign f_sat    = (fbcd_q >> FW) != '0;
   assign b_sat    = (cv_bcd >> BW) != '0;

   bin2bcd_seq u_cv (
      .clk     (clk),
      .rst     (rst),
      .start_i (cv_start),
      .bin_i   (cv_bin),
      .busy_o  (cv_busy),
      .done_o  (cv_done),
      .bcd_o   (cv_bcd)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         bet_sh_q  <= '0;
         w0_sh_q   <= '0;
         w1_sh_q   <= '0;
         w2_sh_q   <= '0;
         dice_sh_q <= '0;
         fbcd_q    <= '0;
         funds_q   <= '0;
         bet_q     <= '0;
         w0_q      <= '0;
         w1_q      <= '0;
         w2_q      <= '0;
         dice_q    <= '0;
         ovf_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE:    state_q <= S_LOAD_F;
            S_LOAD_F: begin
               bet_sh_q  <= disp.displaybet;
               w0_sh_q   <= disp.displaywheel0;
               w1_sh_q   <= disp.displaywheel1;
               w2_sh_q   <= disp.displaywheel2;
               dice_sh_q <= disp.displaydice;
               state_q   <= S_SHIFT_F;
            end
            S_SHIFT_F: if (cv_done) state_q <= S_LOAD_B;
            S_LOAD_B: begin
               fbcd_q  <= cv_bcd;
               state_q <= S_SHIFT_B;
            end
            S_SHIFT_B: if (cv_done) state_q <= S_COMMIT;
            S_COMMIT: begin
               // Whole frame lands in one cycle so the scan never shows a mixed frame
               funds_q <= f_sat ? {FUNDS_DIG{4'd9}} : fbcd_q[FW-1:0];
               bet_q   <= b_sat ? {BET_DIG{4'd9}} : cv_bcd[BW-1:0];
               w0_q    <= w0_sh_q;
               w1_q    <= w1_sh_q;
               w2_q    <= w2_sh_q;
               dice_q  <= dice_sh_q;
               ovf_q   <= f_sat | b_sat;
               state_q <= S_IDLE;
            end
            default:   state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < NDIG; i++) val[i] = '0;
      for (int i = 0; i < FUNDS_DIG; i++) val[i] = funds_q[i];
      for (int i = 0; i < BET_DIG; i++) val[FUNDS_DIG+i] = bet_q[i];
      val[BASE+OFS_WHEEL0] = {1'b0, w0_q};
      val[BASE+OFS_WHEEL1] = {1'b0, w1_q};
      val[BASE+OFS_WHEEL2] = {1'b0, w2_q};
      val[BASE+OFS_DICE]   = {1'b0, dice_q};
   end

`ifdef LEADING_ZERO_BLANK_EN
   always_comb begin : blank_gen
      logic seen;
      blank = '0;
      seen  = 1'b0;
      for (int i = FUNDS_DIG-1; i > 0; i--) begin
         seen     = seen | (funds_q[i] != 4'd0);
         blank[i] = !seen;
      end
      seen = 1'b0;
      for (int i = BET_DIG-1; i > 0; i--) begin
         seen               = seen | (bet_q[i] != 4'd0);
         blank[FUNDS_DIG+i] = !seen;
      end
   end
`else
   assign blank = '0;
`endif

   always_comb begin
      seg_d = seg7(val[dig_q]);
      if (blank[dig_q])
         seg_d = 7'h00;
      else if (dig_q == DW'(BASE+OFS_DICE) && (dice_q == 3'd0 || dice_q == 3'd7))
         seg_d = GLYPH_DASH;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
         dig_q <= '0;
         seg_q <= '0;
         an_q  <= '0;
      end else begin
         seg_q <= seg_d;
         an_q  <= NDIG'(1) << dig_q;
         if (cnt_q == CW'(SCAN_DIV-1)) begin
            cnt_q <= '0;
            dig_q <= (dig_q == DW'(NDIG-1)) ? '0 : dig_q + DW'(1);
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign disp.seg = seg_q;
   assign disp.an  = an_q;
   assign disp.ovf = ovf_q;
endmodule
